// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for both sides of a pipe_skid_reg stage.
// The slave modport is the stage's own view of the bundle.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer, flush,
// an occupancy report and a saturating stall counter.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CNT_W      = 16,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  pipe_skid_reg_if.slave    bus,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StHalf, StFull} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, emit;

  // Handshake outputs decode the state flops only; out_ready never reaches in_ready.
  assign bus.in_ready  = (state_q != StFull);
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = main_q;
  assign stall_cnt     = cnt_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign emit   = bus.out_valid & bus.out_ready;

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StHalf:  occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StHalf;
            main_d  = bus.in_data;
          end
        end
        StHalf: begin
          case ({accept, emit})
            2'b11: main_d = bus.in_data;
            2'b10: begin
              state_d = StFull;
              skid_d  = bus.in_data;
            end
            2'b01:   state_d = StEmpty;
            default: state_d = StHalf;
          endcase
        end
        StFull: begin
          // Skid only drains through main, preserving FIFO order.
          if (emit) begin
            state_d = StHalf;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (bus.out_valid && !bus.out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StEmpty;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised and directed bench for pipe_skid_reg against a queue-based model.
module tb_pipe_skid_reg;

  localparam int unsigned CNT_MAX = 65535;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        flush, stat_clr;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        flush2, stat_clr2;
  logic [1:0]  occupancy2;
  logic [1:0]  stall_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_skid_reg_if #(.DATA_W(32)) bus ();
  pipe_skid_reg_if #(.DATA_W(8))  bus2 ();

  pipe_skid_reg #(.DATA_W(32), .CNT_W(16), .RESET_DATA(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .flush(flush), .stat_clr(stat_clr),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.DATA_W(8), .CNT_W(2), .RESET_DATA(8'h5A)) dut2 (
    .CLK(CLK), .nRST(nRST), .bus(bus2), .flush(flush2), .stat_clr(stat_clr2),
    .occupancy(occupancy2), .stall_cnt(stall_cnt2)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1);
  end

  // Reference model: a FIFO of at most two words plus the stale main value.
  logic [31:0] q[$];
  logic [31:0] stale = 32'h0;
  int unsigned cnt_m = 0;
  logic [31:0] dut_log[$];

  function automatic logic [51:0] exp_vec();
    int sz;
    logic [31:0] d;
    sz = q.size();
    d  = (sz > 0) ? q[0] : stale;
    return {sz < 2, sz > 0, 2'(sz), d, 16'(cnt_m)};
  endfunction

  function automatic logic [51:0] act_vec();
    return {bus.in_ready, bus.out_valid, occupancy, bus.out_data, stall_cnt};
  endfunction

  function automatic bit log_has(input logic [31:0] v);
    foreach (dut_log[i]) if (dut_log[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    stale = 32'h0;
    cnt_m = 0;
  endtask

  task automatic step();
    int sz;
    bit acc, emi, stl, fl, clr;
    logic [31:0] din;
    sz  = q.size();
    acc = bus.in_valid && (sz < 2);
    emi = (sz > 0) && bus.out_ready;
    stl = (sz > 0) && !bus.out_ready;
    fl  = flush;
    clr = stat_clr;
    din = bus.in_data;
    if (bus.out_valid && bus.out_ready && !flush) dut_log.push_back(bus.out_data);
    @(posedge CLK);
    #1;
    if (fl) begin
      q.delete();
      stale = 32'h0;
    end else begin
      if (emi) stale = q.pop_front();
      if (acc) q.push_back(din);
    end
    if (clr) cnt_m = 0;
    else if (stl && cnt_m < CNT_MAX) cnt_m++;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.out_ready = 1;
    flush = 0; stat_clr = 0; flush2 = 0; stat_clr2 = 0;
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
    model_reset();
    step();
    n_checks++;
    if (act_vec() !== {1'b1, 1'b0, 2'd0, 32'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", act_vec(), {1'b1, 1'b0, 2'd0, 32'h0, 16'h0});
    end
    n_checks++;
    if ({bus2.in_ready, bus2.out_valid, occupancy2, bus2.out_data, stall_cnt2}
        !== {1'b1, 1'b0, 2'd0, 8'h5A, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state_dut2: got %h required %h",
               {bus2.in_ready, bus2.out_valid, occupancy2, bus2.out_data, stall_cnt2},
               {1'b1, 1'b0, 2'd0, 8'h5A, 2'd0});
    end
  endtask

  task automatic test_streaming();
    logic [31:0] words[3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1;
      bus.in_data  = words[i];
      step();
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b1, words[i], 1'b1}
          || occupancy > 2'd1) begin
        n_fail++;
        $display("FAIL stream_word%0d: got valid=%b data=%h ready=%b occ=%0d required 1 %h 1 occ<=1",
                 i, bus.out_valid, bus.out_data, bus.in_ready, occupancy, words[i]);
      end
    end
    bus.in_valid = 0;
    step();
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL stream_drain: got %h required %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_back_pressure();
    stat_clr = 1; bus.in_valid = 0;
    step();
    stat_clr = 0;
    dut_log.delete();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'hA; step();
    bus.in_data = 32'hB; step();
    n_checks++;
    if ({occupancy, bus.in_ready} !== {2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d ready=%b required occ=2 ready=0", occupancy, bus.in_ready);
    end
    bus.in_data = 32'hC;
    repeat (3) step();
    n_checks++;
    if ({stall_cnt, occupancy} !== {16'd4, 2'd2}) begin
      n_fail++;
      $display("FAIL bp_stall_cnt: got cnt=%0d occ=%0d required cnt=4 occ=2", stall_cnt, occupancy);
    end
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus.in_valid = 0;
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bp_drain%0d: got %h required %h", i, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (dut_log.size() != 3 || dut_log[0] !== 32'hA || dut_log[1] !== 32'hB
        || dut_log[2] !== 32'hC) begin
      n_fail++;
      $display("FAIL bp_order: got %0d words first=%h required A,B,C", dut_log.size(),
               (dut_log.size() > 0) ? dut_log[0] : 32'hX);
    end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    dut_log.delete();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'h5; step();
    bus.in_data = 32'h6; step();
    cnt_before = stall_cnt;
    flush = 1; bus.in_data = 32'h7;
    step();
    flush = 0; bus.in_valid = 0;
    n_checks++;
    // Flush-cycle stall still counts; the count is never cleared by flush.
    if ({bus.out_valid, occupancy, bus.out_data, stall_cnt}
        !== {1'b0, 2'd0, 32'h0, cnt_before + 16'd1}) begin
      n_fail++;
      $display("FAIL flush_empty: got v=%b occ=%0d data=%h cnt=%0d required v=0 occ=0 data=0 cnt=%0d",
               bus.out_valid, occupancy, bus.out_data, stall_cnt, cnt_before + 16'd1);
    end
    bus.out_ready = 1;
    repeat (3) begin
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL flush_after: got %h required %h", act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (log_has(32'h7) || log_has(32'h5) || log_has(32'h6)) begin
      n_fail++;
      $display("FAIL flush_no_emit: got %0d emitted words required none", dut_log.size());
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq[6];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
    exp_seq[3] = 2'd3; exp_seq[4] = 2'd3; exp_seq[5] = 2'd3;
    bus2.out_ready = 0; bus2.in_valid = 1; bus2.in_data = 8'h3C;
    @(posedge CLK); #1;
    bus2.in_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (stall_cnt2 !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL sat_cnt%0d: got %0d required %0d", i, stall_cnt2, exp_seq[i]);
      end
    end
    stat_clr2 = 1;
    @(posedge CLK); #1;
    stat_clr2 = 0;
    n_checks++;
    if (stall_cnt2 !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_clr: got %0d required 0", stall_cnt2);
    end
    @(posedge CLK); #1;
    n_checks++;
    if ({stall_cnt2, bus2.out_data} !== {2'd1, 8'h3C}) begin
      n_fail++;
      $display("FAIL sat_resume: got cnt=%0d data=%h required cnt=1 data=3c", stall_cnt2, bus2.out_data);
    end
    bus2.out_ready = 1;
    @(posedge CLK); #1;
  endtask

  task automatic test_async_reset();
    dut_log.delete();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_data = 32'h99; step();
    bus.in_valid = 0;
    #3 nRST = 0;
    #1;
    n_checks++;
    if (act_vec() !== {1'b1, 1'b0, 2'd0, 32'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h required %h", act_vec(), {1'b1, 1'b0, 2'd0, 32'h0, 16'h0});
    end
    model_reset();
    @(posedge CLK); #1 nRST = 1;
    bus.out_ready = 1;
    repeat (3) begin
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_after: got %h required %h", act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (log_has(32'h99)) begin
      n_fail++;
      $display("FAIL async_no_emit: got 0x99 emitted required never");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0) ? ((i / 64) % 2 == 0) : 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 15) == 0);
      stat_clr      = ($urandom_range(0, 31) == 0);
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h required %h", i, act_vec(), exp_vec());
      end
    end
    bus.in_valid = 0; flush = 0; stat_clr = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
